// File: rtl/wr_ctrl_pkg.sv
// Shared types and helpers for the burst write master.
// State encoding, three-way minimum and last-beat byte-enable mask.
package wr_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} wr_state_t;

  localparam int BE_MAX = 128;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Low r lanes set; callers only use it for r != 0.
  function automatic logic [BE_MAX-1:0] last_byteenable(input logic [7:0] r);
    return (BE_MAX'(1) << r) - BE_MAX'(1);
  endfunction

endpackage

// File: rtl/wr_burst_len.sv
// Burst length: min(words left, MAX_BURST, beats to next MAX_BURST-aligned boundary).
// Purely combinational, no handshake.
module wr_burst_len
  import wr_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = 16,
  parameter int LOG_MB    = $clog2(MAX_BURST)
) (
  input  logic [ADDR_W-1:0]  words_i,
  input  logic [LOG_MB-1:0]  cur_slot_i,
  output logic [BURST_W-1:0] len_o
);

  logic [31:0] words_sat;
  logic [31:0] to_bound;
  logic [31:0] b;

  always_comb begin
    words_sat = (words_i >= ADDR_W'(MAX_BURST)) ? 32'(MAX_BURST) : 32'(words_i);
    to_bound  = 32'(MAX_BURST) - 32'(cur_slot_i);
    b         = min3(words_sat, 32'(MAX_BURST), to_bound);
  end

  assign len_o = BURST_W'(b);

endmodule

// File: rtl/wr_ctrl_burst.sv
// Avalon-MM burst write master draining a show-ahead FIFO; first write two cycles after the start edge.
// Empty pauses the open burst, waitrequest holds the current beat without popping.
module wr_ctrl_burst
  import wr_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_ctrl,
  input  logic [ADDR_W-1:0]     pkt_begin,
  input  logic [ADDR_W-1:0]     pkt_end,
  input  logic [ADDR_W-1:0]     write_address,
  input  logic                  empty,
  input  logic [DATA_W-1:0]     fifo_out,
  output logic                  rd_from_fifo,
  output logic                  wr_ctrl_rdy,
  output logic                  done,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  write,
  output logic [BURST_W-1:0]    burstcount,
  input  logic                  waitrequest
);

  localparam int BYTES     = DATA_W / 8;
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam int LOG_MB    = $clog2(MAX_BURST);

  wr_state_t             state_q, state_d;
  logic                  wr_ctrl_q;
  logic                  first_q, first_d;
  logic [ADDR_W-1:0]     cur_q, cur_d;
  logic [ADDR_W-1:0]     words_q, words_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [BURST_W-1:0]    beat_q, beat_d;
  logic [LOG_BYTES-1:0]  rem_q, rem_d;

  logic                  start;
  logic [ADDR_W-1:0]     len_in;
  logic [ADDR_W:0]       len_round;
  logic [ADDR_W-1:0]     words_new;
  logic [ADDR_W-1:0]     cur_new;
  logic [ADDR_W-1:0]     setup_words;
  logic [ADDR_W-1:0]     setup_cur;
  logic [BURST_W-1:0]    b_len;
  logic                  beat_ok;
  logic                  last_beat;
  logic                  pkt_last;
  logic [BYTES-1:0]      last_be;

  assign start       = wr_ctrl && !wr_ctrl_q;
  assign len_in      = (pkt_end > pkt_begin) ? (pkt_end - pkt_begin) : '0;
  assign len_round   = {1'b0, len_in} + (ADDR_W+1)'(BYTES - 1);
  assign words_new   = ADDR_W'(len_round >> LOG_BYTES);
  assign cur_new     = write_address & ~ADDR_W'(BYTES - 1);

  // Packet inputs only matter on the first SETUP; later bursts continue from the counters.
  assign setup_words = first_q ? words_new : words_q;
  assign setup_cur   = first_q ? cur_new   : cur_q;

  wr_burst_len #(
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W),
    .LOG_MB    (LOG_MB)
  ) u_burst_len (
    .words_i    (setup_words),
    .cur_slot_i (setup_cur[LOG_BYTES +: LOG_MB]),
    .len_o      (b_len)
  );

  assign beat_ok   = (state_q == BURST) && !empty && !waitrequest;
  assign last_beat = (beat_q == burst_q - BURST_W'(1));
  assign pkt_last  = last_beat && (words_q == ADDR_W'(burst_q));
  assign last_be   = BYTES'(last_byteenable(8'(rem_q)));

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    cur_d        = cur_q;
    words_d      = words_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    rem_d        = rem_q;
    write        = 1'b0;
    rd_from_fifo = 1'b0;
    done         = 1'b0;
    wr_ctrl_rdy  = 1'b0;
    address      = '0;
    burstcount   = '0;
    writedata    = '0;
    byteenable   = '0;

    case (state_q)
      IDLE: begin
        wr_ctrl_rdy = 1'b1;
        if (start) begin
          state_d = SETUP;
          first_d = 1'b1;
        end
      end
      SETUP: begin
        first_d = 1'b0;
        words_d = setup_words;
        cur_d   = setup_cur;
        burst_d = b_len;
        beat_d  = '0;
        if (first_q) rem_d = len_in[LOG_BYTES-1:0];
        state_d = (setup_words == '0) ? DONE : BURST;
      end
      BURST: begin
        address      = cur_q;
        burstcount   = burst_q;
        write        = !empty;
        writedata    = fifo_out;
        rd_from_fifo = beat_ok;
        byteenable   = (pkt_last && rem_q != '0) ? last_be : '1;
        if (beat_ok) begin
          beat_d = beat_q + BURST_W'(1);
          if (last_beat) begin
            cur_d   = cur_q + (ADDR_W'(burst_q) << LOG_BYTES);
            words_d = words_q - ADDR_W'(burst_q);
            state_d = pkt_last ? DONE : SETUP;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge register resets high so a level already present at release is not a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ctrl_q <= 1'b1;
      first_q   <= 1'b0;
      cur_q     <= '0;
      words_q   <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ctrl_q <= wr_ctrl;
      first_q   <= first_d;
      cur_q     <= cur_d;
      words_q   <= words_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      rem_q     <= rem_d;
    end
  end

endmodule

// File: tb/tb_wr_ctrl_burst.sv
// Directed and randomized packets for wr_ctrl_burst (DATA_W=32, MAX_BURST=8) against a beat-list model.
module tb_wr_ctrl_burst;

  logic        clk, reset, wr_ctrl, empty, waitrequest;
  logic [31:0] pkt_begin, pkt_end, write_address, fifo_out;
  logic        rd_from_fifo, wr_ctrl_rdy, done, write;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic [15:0] burstcount;

  wr_ctrl_burst #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(8), .BURST_W(16)) dut (
    .clk(clk), .reset(reset), .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .write_address(write_address), .empty(empty), .fifo_out(fifo_out),
    .rd_from_fifo(rd_from_fifo), .wr_ctrl_rdy(wr_ctrl_rdy), .done(done), .address(address),
    .writedata(writedata), .byteenable(byteenable), .write(write), .burstcount(burstcount),
    .waitrequest(waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] bc;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  beat_t       expq[$];
  logic [31:0] fq[$];
  int total = 0;
  int bad = 0;
  int cyc, acc, last_acc, done_cyc, nwords;
  int pe_g, pw_g, empty_at, wait_at, w_left;
  bit e_forced, got_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat sequence derived from packet length and destination alignment.
  task automatic build_exp(input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] wa, input int dbase);
    logic [31:0] len, cur, rem, bl, tb, d;
    logic [3:0]  be;
    int idx;
    len = (e > b) ? e - b : 32'd0;
    nwords = int'((len + 3) / 4);
    fq.delete();
    expq.delete();
    for (int i = 0; i < nwords; i++) begin
      d = (dbase >= 0) ? 32'(dbase + i) : $urandom;
      fq.push_back(d);
    end
    cur = wa & ~32'h3;
    rem = 32'(nwords);
    idx = 0;
    while (rem > 0) begin
      bl = (rem > 8) ? 32'd8 : rem;
      tb = 32'd8 - ((cur / 4) % 8);
      if (bl > tb) bl = tb;
      for (int k = 0; k < int'(bl); k++) begin
        be = 4'hF;
        if (idx == nwords - 1 && (len % 4) != 0) be = 4'((32'd1 << (len % 4)) - 1);
        expq.push_back('{addr: cur, bc: 16'(bl), be: be, data: fq[idx]});
        idx++;
      end
      cur = cur + bl * 4;
      rem = rem - bl;
    end
  endtask

  // One clock cycle: drive FIFO/slave at negedge, check outputs, apply pop at posedge.
  task automatic tick();
    bit st_e, st_w, pop;
    beat_t bt;
    cyc++;
    st_e = ($urandom_range(99) < pe_g);
    if (empty_at >= 0 && acc == empty_at && !e_forced && cyc >= 2) begin
      st_e = 1'b1;
      e_forced = 1'b1;
    end
    st_w = ($urandom_range(99) < pw_g);
    if (wait_at >= 0 && acc == wait_at && w_left > 0 && cyc >= 2) begin
      st_w = 1'b1;
      w_left--;
    end
    empty = (fq.size() == 0) || st_e;
    fifo_out = (fq.size() != 0) ? fq[0] : 32'h0;
    waitrequest = st_w;
    #2;
    chk("rd_from_fifo", rd_from_fifo, write && !waitrequest);
    if (cyc == 1) begin
      chk("setup_rdy", wr_ctrl_rdy, 1'b0);
      chk("setup_write", write, 1'b0);
    end
    if (empty) chk("write_while_empty", write, 1'b0);
    if (write) chk("writedata_is_head", writedata, fifo_out);
    pop = rd_from_fifo;
    if (write && !waitrequest) begin
      chk("beat_expected", expq.size() != 0, 1'b1);
      if (expq.size() != 0) begin
        bt = expq.pop_front();
        chk("beat_address", address, bt.addr);
        chk("beat_burstcount", burstcount, bt.bc);
        chk("beat_byteenable", byteenable, bt.be);
        chk("beat_data", writedata, bt.data);
      end
      acc++;
      last_acc = cyc;
    end
    if (done && !got_done) begin
      got_done = 1'b1;
      done_cyc = cyc;
    end
    @(posedge clk);
    if (pop && fq.size() != 0) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic start_pkt(input logic [31:0] b, input logic [31:0] e, input logic [31:0] wa,
                           input int dbase, input int pe, input int pw,
                           input int eat, input int wat, input int wcyc);
    build_exp(b, e, wa, dbase);
    pe_g = pe; pw_g = pw; empty_at = eat; wait_at = wat; w_left = wcyc;
    e_forced = 1'b0; got_done = 1'b0;
    cyc = 0; acc = 0; last_acc = -10; done_cyc = -1;
    pkt_begin = b; pkt_end = e; write_address = wa;
    wr_ctrl = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_packet(input logic [31:0] b, input logic [31:0] e, input logic [31:0] wa,
                            input int dbase, input int pe, input int pw,
                            input int eat, input int wat, input int wcyc, input bit retog);
    start_pkt(b, e, wa, dbase, pe, pw, eat, wat, wcyc);
    while (!got_done && cyc < 400) begin
      if (cyc >= 1) begin
        pkt_begin = $urandom; pkt_end = $urandom; write_address = $urandom;
      end
      if (retog && nwords > 0 && cyc == 1) wr_ctrl = 1'b0;
      if (retog && nwords > 0 && cyc == 2) wr_ctrl = 1'b1;
      tick();
    end
    chk("done_seen", got_done, 1'b1);
    if (nwords == 0) chk("done_latency_empty", done_cyc, 2);
    else chk("done_after_last_beat", done_cyc, last_acc + 1);
    chk("beats_missing", expq.size(), 0);
    chk("fifo_not_drained", fq.size(), 0);
    #2;
    chk("done_one_cycle", done, 1'b0);
    chk("rdy_after_done", wr_ctrl_rdy, 1'b1);
    wr_ctrl = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk("held_no_restart_rdy", wr_ctrl_rdy, 1'b1);
      chk("held_no_restart_wr", write, 1'b0);
    end
    wr_ctrl = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; wr_ctrl = 1'b1; empty = 1'b1; waitrequest = 1'b0;
    pkt_begin = '0; pkt_end = '0; write_address = '0; fifo_out = '0;
    #3;
    chk("rst_rdy", wr_ctrl_rdy, 1'b1);
    chk("rst_write", write, 1'b0);
    chk("rst_rd", rd_from_fifo, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_burstcount", burstcount, 16'h0);
    chk("rst_byteenable", byteenable, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    // wr_ctrl already high at release must not start a packet
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk("high_at_release_rdy", wr_ctrl_rdy, 1'b1);
    end
    wr_ctrl = 1'b0;
    @(negedge clk);

    run_packet(32'd0, 32'd32, 32'h8000, 10, 0, 0, -1, -1, 0, 1'b0);
    run_packet(32'd0, 32'd32, 32'h8000, 10, 0, 0, 4, -1, 0, 1'b0);
    run_packet(32'd0, 32'd32, 32'h8000, 10, 0, 0, -1, 0, 2, 1'b0);
    run_packet(32'd0, 32'd0, 32'h8000, 10, 0, 0, -1, -1, 0, 1'b0);
    run_packet(32'd40, 32'd8, 32'h8000, 10, 0, 0, -1, -1, 0, 1'b0);
    run_packet(32'd0, 32'd42, 32'h8018, 100, 0, 0, -1, -1, 0, 1'b1);
    run_packet(32'd3, 32'd40, 32'hFFFF_FFE4, -1, 20, 20, -1, -1, 0, 1'b1);

    // Reset during the third beat of a burst, then a clean packet.
    start_pkt(32'd0, 32'd32, 32'h9000, 50, 0, 0, -1, -1, 0);
    while (acc < 2 && cyc < 100) tick();
    chk("pre_reset_beats", acc, 2);
    empty = 1'b0;
    fifo_out = (fq.size() != 0) ? fq[0] : 32'h0;
    wr_ctrl = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_write", write, 1'b0);
    chk("midrst_rd", rd_from_fifo, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_rdy", wr_ctrl_rdy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("postrst_done", done, 1'b0);
    chk("postrst_rdy", wr_ctrl_rdy, 1'b1);
    @(negedge clk);
    run_packet(32'd0, 32'd20, 32'hA004, 70, 0, 0, -1, -1, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [31:0] rb, re, ra;
      rb = 32'($urandom_range(60));
      re = 32'($urandom_range(130));
      ra = (n % 5 == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(255))) : $urandom;
      run_packet(rb, re, ra, -1, 25, 25, -1, -1, 0, bit'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wr_ctrl_burst.md
# wr_ctrl_burst

Parametrised Avalon-MM burst write master that drains packet words from a show-ahead FIFO into memory. It is the next generation of the packet write controller. Over a single fixed burst it adds:
- configurable data width and maximum burst length;
- automatic splitting of a packet into boundary-aligned bursts;
- partial-word byte enables on the last beat;
- edge-triggered start with a completion pulse.

It sits between the capture FIFO and the SDRAM/on-chip memory Avalon slave.

## Interface
Parameters:
- DATA_W, 32, data bus width in bits; power of 2, ≥ 16.
- ADDR_W, 32, byte address width.
- MAX_BURST, 8, maximum beats per burst; power of 2, ≥ 2.
- BURST_W, 16, burstcount width; must hold MAX_BURST.

Ports (BYTES = DATA_W/8):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_ctrl  in  1  start request; a packet is accepted on a 0→1 transition while idle.
- pkt_begin  in  ADDR_W  packet start byte offset.
- pkt_end  in  ADDR_W  packet end byte offset, exclusive.
- write_address  in  ADDR_W  destination byte address; low log2(BYTES) bits ignored.
- empty  in  1  FIFO empty.
- fifo_out  in  DATA_W  FIFO head word; valid while !empty.
- rd_from_fifo  out  1  FIFO pop.
- wr_ctrl_rdy  out  1  high in IDLE.
- done  out  1  one-cycle pulse at packet completion.
- address  out  ADDR_W  Avalon burst start address.
- writedata  out  DATA_W  Avalon write data.
- byteenable  out  BYTES  Avalon byte enables.
- write  out  1  Avalon write.
- burstcount  out  BURST_W  Avalon burst length.
- waitrequest  in  1  Avalon slave stall.

## Operation
States:
- **IDLE**: start edge seen → **SETUP**.
- **SETUP**: latch the packet and burst parameters (below); if words = 0 → **DONE**, else → **BURST**.
- **BURST**: beats issued (below); last beat of a burst accepted → **SETUP** if words remain, else **DONE**.
- **DONE**: done = 1 for one cycle → **IDLE**.

SETUP latches:
- len = pkt_end − pkt_begin if pkt_end > pkt_begin, else 0.
- words = ceil(len/BYTES).
- cur = write_address with the low bits cleared (first SETUP only).
- Burst length b = min(words remaining, MAX_BURST, MAX_BURST − (cur/BYTES mod MAX_BURST)). Bursts never cross a MAX_BURST·BYTES-aligned boundary.

BURST outputs:
- address = cur and burstcount = b, held constant for the whole burst.
- write = !empty.
- writedata = fifo_out.
- rd_from_fifo = write && !waitrequest.
- A beat completes on write && !waitrequest.
- After the burst: cur += b·BYTES, words remaining −= b.

Byte enables:
- All ones except the final beat of the packet.
- On the final beat, if r = len mod BYTES ≠ 0, only the low r bits are set.

Edge detection and busy behaviour:
- The edge detector is a registered copy of wr_ctrl.
- wr_ctrl held high does not retrigger.
- A rising edge outside IDLE is ignored.
- Inputs other than FIFO/Avalon signals are sampled only in SETUP; changes mid-packet have no effect.

Address arithmetic:
- Modulo 2^ADDR_W; wrap is silent.

## Timing
Reset values (asserted asynchronously, released synchronously):
- State = IDLE; wr_ctrl_rdy = 1.
- write, rd_from_fifo, done = 0; address, writedata, burstcount = 0; byteenable = 0.
- The edge-detect register resets to 1, so a wr_ctrl already high at reset release does not start a packet.

Latency and throughput:
- Start edge sampled at edge N → SETUP in cycle N+1 → first write possible in cycle N+2.
- One SETUP cycle between consecutive bursts.
- Zero-length packet: done is high in cycle N+2 and no write is issued.
- done is asserted the cycle after the final beat is accepted; wr_ctrl_rdy rises the cycle after done.

Stalls:
- empty stall: write drops and the burst stays open (legal Avalon burst pause).
- waitrequest stall: writedata, byteenable and write are held and no pop occurs.
- Both empty and waitrequest high: treated as an empty stall.

Mid-operation reset:
- Reset asserted mid-burst abandons the burst immediately; no completion pulse.

## Structure
- Package wr_ctrl_pkg holds:
  - state enum wr_state_t {IDLE, SETUP, BURST, DONE};
  - function min3;
  - function last_byteenable(r).
- One sub-module, wr_burst_len: combinational b computation from words remaining and cur. It is instantiated once and unit-testable on its own.
- Main FSM, counters and Avalon outputs stay in wr_ctrl_burst (~200 lines).

## Test plan
All scenarios use DATA_W=32, MAX_BURST=8.
- **Normal burst**: pkt 0..32 at 0x8000, FIFO 10..17, no stalls → one burst, address 0x8000, burstcount 8, writedata 10..17, byteenable 0xF, done one cycle after beat 8.
- **FIFO stall**: same packet, empty high for 1 cycle after beat 4 → write low that cycle, address/burstcount unchanged, 8 beats in order 10..17.
- **Slave stall**: waitrequest high for 2 cycles on beat 1 → writedata 10 held, rd_from_fifo low both cycles, no duplicate or lost beat.
- **Empty packet**: pkt_end = 0 → no write, done pulse in cycle N+2, wr_ctrl_rdy high the next cycle; wr_ctrl held high does not restart.
- **Split and partial word**: write_address 0x8018, len 42 bytes → bursts of 2 @0x8018 and 9 words split as 8 @0x8020 and 1 @0x8040; last byteenable 0x3.
- **Reset mid-burst**: reset low during beat 3 → write, rd_from_fifo and done are 0 immediately; wr_ctrl_rdy = 1; a new packet starts cleanly after release.
